// File: rtl/fnd_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package fnd_pkg;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } conv_state_e;

  // Active-low pattern for one BCD digit; non-decimal codes render blank.
  function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per cycle).
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  // Digits needed for the widest input, plus one spare so no carry is lost.
  localparam int unsigned FULL_DIGITS = (DATA_W * 3) / 10 + 1;
  localparam int unsigned BCD_DIGITS  =
    ((FULL_DIGITS > NUM_DIGITS) ? FULL_DIGITS : NUM_DIGITS) + 1;
  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  conv_state_e       state_q;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj_c;
  logic [CNT_W-1:0]  cnt_q;
  logic              carry_q;
  logic              busy_q;
  logic              done_q;

  always_comb begin
    adj_c = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bin_q   <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q   <= {adj_c[BCD_W-2:0], bin_q[DATA_W-1]};
          bin_q   <= {bin_q[DATA_W-2:0], 1'b0};
          carry_q <= carry_q | adj_c[BCD_W-1];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q[4*NUM_DIGITS-1:0];
  assign ovf  = carry_q | (|bcd_q[BCD_W-1:4*NUM_DIGITS]);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed seven-segment display driver: BCD conversion, digit scan,
// leading-zero blanking, decimal points, overflow dashes and blinking.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned BLINK_DIV  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data,
  input  logic                  data_valid,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] seg_comm,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic                    conv_done;
  logic                    conv_ovf;
  logic [4*NUM_DIGITS-1:0] conv_bcd;

  logic [DIV_W-1:0]        div_q;
  logic [IDX_W-1:0]        dig_q;
  logic [BLK_W-1:0]        blk_cnt_q;
  logic                    blink_on_q;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic                    ovf_q;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   comm_q;

  logic                    tick_c;
  logic [3:0]              cur_digit_c;
  logic                    upper_zero_c;
  logic [7:0]              seg_d;
  logic [NUM_DIGITS-1:0]   comm_d;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (data_valid),
    .bin   (data),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  assign tick_c = (div_q == DIV_W'(SCAN_DIV - 1));

  // Select the scanned digit and test whether it and everything above it is zero.
  always_comb begin
    cur_digit_c  = 4'd0;
    upper_zero_c = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (IDX_W'(i) == dig_q) cur_digit_c = disp_q[4*i +: 4];
      if (IDX_W'(i) >= dig_q && disp_q[4*i +: 4] != 4'd0) upper_zero_c = 1'b0;
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blank_lz && dig_q != '0 && upper_zero_c) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_of_digit(cur_digit_c);
    end
    if (dp_mask[dig_q]) seg_d[7] = 1'b0;
    comm_d = (blink_en && !blink_on_q) ? '1 : ~(NUM_DIGITS'(1) << dig_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      dig_q      <= '0;
      blk_cnt_q  <= '0;
      blink_on_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      seg_q      <= SEG_BLANK;
      comm_q     <= '1;
    end else begin
      seg_q  <= seg_d;
      comm_q <= comm_d;
      if (conv_done) begin
        disp_q <= conv_bcd;
        ovf_q  <= conv_ovf;
      end
      if (tick_c) begin
        div_q <= '0;
        if (dig_q == IDX_W'(NUM_DIGITS - 1)) begin
          dig_q <= '0;
          // Blink phase flips after BLINK_DIV complete frames.
          if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt_q  <= '0;
            blink_on_q <= ~blink_on_q;
          end else begin
            blk_cnt_q <= blk_cnt_q + BLK_W'(1);
          end
        end else begin
          dig_q <= dig_q + IDX_W'(1);
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign seg      = seg_q;
  assign seg_comm = comm_q;
  assign overflow = ovf_q;

endmodule
